aes_mix_columns_pipe: RTL and testbench



---
 rtl/aes_mix_columns_pipe.sv | 177 +++++++++++++++++
 tb/tb_aes_mix_columns_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mix_columns_pipe.sv
// AES MixColumns / InvMixColumns round stage with pointer tag, per-pointer beat counters and sticky debug.
// Latency: a beat accepted at edge N is presented on out_* after edge N+PIPE_STAGES-1.
// Backpressure: valid/ready; each stage loads when empty or draining, so in_rdy follows out_rdy combinationally when full.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_data/in_inv/in_pntr/in_vld/in_rdy     input beat (128-bit state, inverse select, pointer tag)
//   out_data/out_pntr/out_vld/out_rdy        output beat
//   cpu_rd/cpu_addr/cpu_rd_data              CPU read port: counters at 0..NUM_PNTR-1, debug at NUM_PNTR
module aes_mix_columns_pipe #(
    parameter int NUM_PNTR    = 4,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16,
    parameter int CPU_W       = 32,
    localparam int PNTR_W     = (NUM_PNTR > 1) ? $clog2(NUM_PNTR) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      in_data,
    input  logic              in_inv,
    input  logic [PNTR_W-1:0] in_pntr,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [127:0]      out_data,
    output logic [PNTR_W-1:0] out_pntr,
    output logic              out_vld,
    input  logic              out_rdy,
    input  logic              cpu_rd,
    input  logic [PNTR_W:0]   cpu_addr,
    output logic [CPU_W-1:0]  cpu_rd_data
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant: every MixColumns coefficient fits in 4 bits,
    // so three xtime steps cover both directions.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Circulant matrix: output byte i uses coefficient row rotated right by i.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [3:0]  coef [4];
        logic [7:0]  a    [4];
        logic [7:0]  b;
        logic [31:0] res;
        coef[0] = inv ? 4'he : 4'h2;
        coef[1] = inv ? 4'hb : 4'h3;
        coef[2] = inv ? 4'hd : 4'h1;
        coef[3] = inv ? 4'h9 : 4'h1;
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        res = '0;
        for (int i = 0; i < 4; i++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], coef[2'(j - i)]);
            res[31-8*i -: 8] = b;
        end
        return res;
    endfunction

    logic [127:0]           w_mix;
    logic [PIPE_STAGES-1:0] w_ld;
    logic [PIPE_STAGES-1:0] w_adv;
    logic                   w_acc;

    logic [127:0]           r_dat  [PIPE_STAGES];
    logic [PNTR_W-1:0]      r_pntr [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] r_vld;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_mix[127-32*c -: 32] = mix_col(in_data[127-32*c -: 32], in_inv);
    end

    // Ready ripples back from the output: a stage advances when its successor
    // can load, and it can load when it is empty or advancing.
    always_comb begin : p_handshake
        logic v_nxt_ld;
        w_ld     = '0;
        w_adv    = '0;
        v_nxt_ld = out_rdy;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
            w_adv[i] = r_vld[i] && v_nxt_ld;
            w_ld[i]  = !r_vld[i] || w_adv[i];
            v_nxt_ld = w_ld[i];
        end
    end

    assign in_rdy = w_ld[0];
    assign w_acc  = in_vld && in_rdy;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_vld[0]  <= 1'b0;
                    r_dat[0]  <= '0;
                    r_pntr[0] <= '0;
                end else if (w_ld[0]) begin
                    r_vld[0] <= w_acc;
                    if (w_acc) begin
                        r_dat[0]  <= w_mix;
                        r_pntr[0] <= in_pntr;
                    end
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_vld[g]  <= 1'b0;
                    r_dat[g]  <= '0;
                    r_pntr[g] <= '0;
                end else if (w_ld[g]) begin
                    r_vld[g] <= w_adv[g-1];
                    if (w_adv[g-1]) begin
                        r_dat[g]  <= r_dat[g-1];
                        r_pntr[g] <= r_pntr[g-1];
                    end
                end
            end
        end
    end

    assign out_vld  = r_vld[PIPE_STAGES-1];
    assign out_data = r_dat[PIPE_STAGES-1];
    assign out_pntr = r_pntr[PIPE_STAGES-1];

    logic [CNT_W-1:0]    r_cnt [NUM_PNTR];
    logic [NUM_PNTR-1:0] w_wrap_vec;

    for (genvar g = 0; g < NUM_PNTR; g++) begin : g_cnt
        logic w_hit;
        assign w_hit         = w_acc && (in_pntr == PNTR_W'(g));
        assign w_wrap_vec[g] = w_hit && (r_cnt[g] == '1);
        always_ff @(posedge clk or posedge reset) begin
            if (reset)      r_cnt[g] <= '0;
            else if (w_hit) r_cnt[g] <= r_cnt[g] + CNT_W'(1);
        end
    end

    logic [1:0]       r_dbg;
    logic [1:0]       w_dbg_set;
    logic             w_dbg_clr;
    logic [CPU_W-1:0] w_rd_val;
    logic [CPU_W-1:0] r_rd_data;

    assign w_dbg_set = {|w_wrap_vec, cpu_rd && w_acc};
    assign w_dbg_clr = cpu_rd && (cpu_addr == (PNTR_W+1)'(NUM_PNTR));

    // Clear-on-read, with a same-cycle set taking priority over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_dbg <= 2'b00;
        else       r_dbg <= (w_dbg_clr ? 2'b00 : r_dbg) | w_dbg_set;
    end

    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_PNTR; k++) begin
            if (cpu_addr == (PNTR_W+1)'(k)) w_rd_val = CPU_W'(r_cnt[k]);
        end
        if (cpu_addr == (PNTR_W+1)'(NUM_PNTR)) w_rd_val = CPU_W'(r_dbg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_rd_data <= '0;
        else if (cpu_rd) r_rd_data <= w_rd_val;
    end

    assign cpu_rd_data = r_rd_data;

endmodule

// File: tb/tb_aes_mix_columns_pipe.sv
// Testbench for aes_mix_columns_pipe: directed vectors, randomized beats against a GF(2^8) matrix model.
// Latency: not applicable.
// Backpressure: drives out_rdy low in directed windows and randomly in bulk phases.
module tb_aes_mix_columns_pipe;

    localparam int NP  = 4;
    localparam int PS  = 3;
    localparam int CW  = 4;
    localparam int CPW = 32;
    localparam int PW  = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [127:0]   in_data = '0;
    logic           in_inv = 1'b0;
    logic [PW-1:0]  in_pntr = '0;
    logic           in_vld = 1'b0;
    logic           in_rdy;
    logic [127:0]   out_data;
    logic [PW-1:0]  out_pntr;
    logic           out_vld;
    logic           out_rdy = 1'b1;
    logic           cpu_rd = 1'b0;
    logic [PW:0]    cpu_addr = '0;
    logic [CPW-1:0] cpu_rd_data;

    always #5 clk = ~clk;

    aes_mix_columns_pipe #(
        .NUM_PNTR(NP), .PIPE_STAGES(PS), .CNT_W(CW), .CPU_W(CPW)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_inv(in_inv), .in_pntr(in_pntr), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_pntr(out_pntr), .out_vld(out_vld), .out_rdy(out_rdy),
        .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_rd_data(cpu_rd_data)
    );

    typedef struct {
        logic [127:0]  dat;
        logic [PW-1:0] pntr;
    } beat_t;

    typedef logic [7:0] mat_t [4][4];
    localparam mat_t M_FWD = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                               '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    localparam mat_t M_INV = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                               '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

    beat_t          q[$];
    beat_t          b_mon;
    int             n_chk = 0;
    int             n_fail = 0;
    int             n_acc = 0;
    int             n_out = 0;
    logic           rnd_rdy = 1'b0;
    logic           p_stall = 1'b0;
    logic [127:0]   p_dat = '0;
    logic [PW-1:0]  p_pntr = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   acc;
        mat_t         m;
        if (inv) m = M_INV;
        else     m = M_FWD;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) a[rr] = s[127-32*c-8*rr -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(m[rr][j], a[j]);
                r[127-32*c-8*rr -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Output monitor: scoreboard order/data/pntr and hold-while-stalled.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_vld",  128'(out_vld),  128'(1));
                chk("hold_dat",  out_data,       p_dat);
                chk("hold_pntr", 128'(out_pntr), 128'(p_pntr));
            end
            if (out_vld && out_rdy) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 128'(out_vld), 128'(0));
                end else begin
                    b_mon = q.pop_front();
                    n_out++;
                    chk("out_dat",  out_data,       b_mon.dat);
                    chk("out_pntr", 128'(out_pntr), 128'(b_mon.pntr));
                end
            end
            p_stall = out_vld && !out_rdy;
            p_dat   = out_data;
            p_pntr  = out_pntr;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [127:0] d, input logic inv, input logic [PW-1:0] p,
                        input logic [127:0] exp);
        bit    acc;
        beat_t b;
        acc     = 1'b0;
        in_data = d;
        in_inv  = inv;
        in_pntr = p;
        in_vld  = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (in_rdy) begin
                acc    = 1'b1;
                b.dat  = exp;
                b.pntr = p;
                q.push_back(b);
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        if (!acc) chk("send_timeout", 128'(in_rdy), 128'(1));
    endtask

    task automatic send_rand(input logic inv, input logic [PW-1:0] p);
        logic [127:0] x;
        x = {$urandom, $urandom, $urandom, $urandom};
        send(x, inv, p, model_mix(x, inv));
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 128'(q.size()), 128'(0));
    endtask

    task automatic cpu_read(input logic [PW:0] a, output logic [CPW-1:0] d);
        cpu_rd   = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        d      = cpu_rd_data;
    endtask

    logic [CPW-1:0] rd;
    logic [127:0]   x;
    logic [127:0]   y;
    logic [PW-1:0]  pp;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld",  128'(out_vld),     128'(0));
        chk("rst_out_data", out_data,          128'(0));
        chk("rst_out_pntr", 128'(out_pntr),    128'(0));
        chk("rst_rd_data",  128'(cpu_rd_data), 128'(0));
        reset = 1'b0;
        #1;
        chk("rst_in_rdy", 128'(in_rdy), 128'(1));

        // Per-pointer counters
        repeat (5) send_rand(1'b0, 2'd2);
        repeat (3) send_rand(1'b1, 2'd0);
        drain();
        cpu_read(3'd2, rd); chk("cnt2", 128'(rd), 128'(5));
        cpu_read(3'd0, rd); chk("cnt0", 128'(rd), 128'(3));
        cpu_read(3'd1, rd); chk("cnt1", 128'(rd), 128'(0));
        cpu_read(3'd4, rd); chk("dbg_idle", 128'(rd), 128'(0));

        // CNT_W=4: sixteen beats wrap pointer 1 back to zero
        for (int i = 0; i < 16; i++) send_rand(1'($urandom_range(0, 1)), 2'd1);
        drain();
        cpu_read(3'd1, rd); chk("cnt1_wrap", 128'(rd), 128'(0));
        cpu_read(3'd6, rd); chk("addr6_zero", 128'(rd), 128'(0));
        cpu_read(3'd7, rd); chk("addr7_zero", 128'(rd), 128'(0));
        cpu_read(3'd4, rd); chk("dbg_wrap", 128'(rd), 128'(2));
        cpu_read(3'd4, rd); chk("dbg_wrap_clr", 128'(rd), 128'(0));
        cpu_read(3'd2, rd); chk("cnt2_again", 128'(rd), 128'(5));
        repeat (3) @(posedge clk);
        #1;
        chk("rd_hold", 128'(cpu_rd_data), 128'(5));

        // Read strobe coincident with acceptance sets debug bit0
        cpu_rd = 1'b1; cpu_addr = 3'd0;
        send_rand(1'b0, 2'd3);
        cpu_rd = 1'b0;
        drain();
        cpu_read(3'd4, rd); chk("dbg_bit0", 128'(rd), 128'(1));
        cpu_read(3'd4, rd); chk("dbg_bit0_clr", 128'(rd), 128'(0));
        // Debug read in the same cycle as a set event: read sees old, set survives
        cpu_rd = 1'b1; cpu_addr = 3'd4;
        send_rand(1'b0, 2'd3);
        cpu_rd = 1'b0;
        chk("dbg_clr_cycle_rd", 128'(cpu_rd_data), 128'(0));
        cpu_read(3'd4, rd); chk("dbg_set_wins", 128'(rd), 128'(1));
        cpu_read(3'd4, rd); chk("dbg_set_wins_clr", 128'(rd), 128'(0));
        drain();

        // Known-answer vectors and latency from an empty pipeline
        send({32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b0, 2'd1,
             {32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'hd5d5d7d6});
        @(negedge clk); chk("lat_e0", 128'(out_vld), 128'(0));
        @(negedge clk); chk("lat_e1", 128'(out_vld), 128'(0));
        @(negedge clk); chk("lat_e2", 128'(out_vld), 128'(1));
        @(posedge clk); #1;
        send({4{32'h8e4da1bc}}, 1'b1, 2'd2, {4{32'hdb135345}});
        send({32'h2d26314c, 32'h01010101, 32'hc6c6c6c6, 32'h2d26314c}, 1'b0, 2'd3,
             {32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8});
        send({32'h4d7ebdf8, 32'h9fdc589d, 32'hd5d5d7d6, 32'h8e4da1bc}, 1'b1, 2'd0,
             {32'h2d26314c, 32'hf20a225c, 32'hd4d4d4d5, 32'hdb135345});
        drain();

        // Randomized mixed-direction beats under random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 200; i++) send_rand(1'($urandom_range(0, 1)), PW'($urandom_range(0, 3)));
        // Forward then inverse must restore the original state
        for (int i = 0; i < 500; i++) begin
            x  = {$urandom, $urandom, $urandom, $urandom};
            pp = PW'($urandom_range(0, 3));
            y  = model_mix(x, 1'b0);
            send(x, 1'b0, pp, y);
            send(y, 1'b1, pp, x);
        end
        rnd_rdy = 1'b0;
        out_rdy = 1'b1;
        drain();

        // Directed stall: pipeline fills to PS, then in_rdy tracks out_rdy
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand(1'b0, PW'(i));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_rdy = 1'b0;
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("bp_in_rdy_low", 128'(in_rdy), 128'(0));
                chk("bp_fill", 128'(n_acc - n_out), 128'(PS));
                @(posedge clk);
                #1 out_rdy = 1'b1;
                @(negedge clk);
                chk("bp_in_rdy_comb", 128'(in_rdy), 128'(1));
            end
        join
        drain();

        // Asynchronous reset with two beats in flight
        out_rdy = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 3'd0;
        send_rand(1'b0, 2'd1);
        send_rand(1'b0, 2'd2);
        cpu_rd = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_out_vld",  128'(out_vld),  128'(0));
        chk("arst_out_data", out_data,       128'(0));
        chk("arst_out_pntr", 128'(out_pntr), 128'(0));
        q.delete();
        n_acc = 0;
        n_out = 0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        out_rdy = 1'b1;
        #1;
        chk("arst_in_rdy", 128'(in_rdy), 128'(1));
        cpu_read(3'd1, rd); chk("arst_cnt1", 128'(rd), 128'(0));
        cpu_read(3'd2, rd); chk("arst_cnt2", 128'(rd), 128'(0));
        cpu_read(3'd4, rd); chk("arst_dbg",  128'(rd), 128'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("arst_no_stale", 128'(out_vld), 128'(0));
        end

        chk("sb_empty", 128'(q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
